sync_fifo_fwft: RTL and testbench
=================================

SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 10, depth = 2**ADDR_WIDTH words.
REQ-003 The block SHALL take parameter FWFT, default 0, 0 = standard read, 1 = first-word-fall-through.
REQ-004 The block SHALL take parameter AF_LEVEL, default 2**ADDR_WIDTH-2, almost-full threshold in words.
REQ-005 The block SHALL take parameter AE_LEVEL, default 2, almost-empty threshold in words.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset; the ports are listed below.
REQ-007 clk  in  1  the only clock; all state changes on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 w_data  in  DATA_WIDTH  write word.
REQ-010 w_push  in  1  write request.
REQ-011 w_full  out  1  no free location.
REQ-012 w_almost_full  out  1  count >= AF_LEVEL.
REQ-013 r_pop  in  1  read request / consume.
REQ-014 r_data  out  DATA_WIDTH  read word.
REQ-015 r_valid  out  1  r_data holds a valid word.
REQ-016 r_empty  out  1  no word available.
REQ-017 r_almost_empty  out  1  count <= AE_LEVEL.
REQ-018 d_count  out  ADDR_WIDTH+1  words held, 0..2**ADDR_WIDTH.
REQ-019 flush  in  1  synchronous clear of contents.
REQ-020 overflow  out  1  sticky: push attempted while full.
REQ-021 underflow  out  1  sticky: pop attempted while empty.
REQ-022 err_clr  in  1  clears overflow and underflow.

Function
REQ-023 Pointers SHALL be ADDR_WIDTH+1 bits; the extra MSB distinguishes full (MSBs differ, rest equal) from empty (all equal); wrap from 2**ADDR_WIDTH-1 to 0 is natural modulo arithmetic.
REQ-024 A push with w_full=0 SHALL write w_data at the write pointer and increment it; d_count, r_empty and the almost flags SHALL reflect it on the next cycle.
REQ-025 A push with w_full=1 SHALL be dropped and set overflow on the next cycle; a simultaneous pop SHALL still be accepted.
REQ-026 A pop with r_empty=1 SHALL be ignored and set underflow on the next cycle; a simultaneous push SHALL still be accepted.
REQ-027 A simultaneous accepted push and pop SHALL leave d_count unchanged.
REQ-028 With FWFT=0, r_data SHALL update one cycle after an accepted pop, and r_valid SHALL pulse high for that cycle only; r_data SHALL hold its value otherwise.
REQ-029 With FWFT=1, r_data SHALL present the head word whenever r_empty=0, r_valid SHALL equal ~r_empty, and a pop SHALL present the next word (or raise r_empty) on the next cycle.
REQ-030 Push-to-visible latency SHALL be one cycle in both modes, including a push into an empty FIFO.
REQ-031 flush SHALL zero the pointers and d_count on the next edge, override push and pop in the same cycle, and leave overflow/underflow unchanged.
REQ-032 err_clr SHALL clear both sticky flags; a new error in the same cycle SHALL win.

Reset
REQ-033 rst SHALL immediately force: pointers 0, d_count 0, r_empty 1, r_almost_empty 1, w_full 0, w_almost_full 0, r_valid 0, r_data 0, overflow 0, underflow 0.
REQ-034 Memory contents SHALL NOT be reset; a reset mid-operation SHALL discard all stored words.

Structure
REQ-035 The shared package fifo_pkg SHALL hold the FWFT mode constants and the pointer-width function.
REQ-036 Storage SHALL be a single sub-module fifo_mem: single-clock, one write port and one read port, registered read.

Verification
REQ-037 DATA_WIDTH=8, ADDR_WIDTH=4, FWFT=0: push 0x01..0x10 -> w_full=1, d_count=16, w_almost_full from count 14; pop 16 -> r_data 0x01..0x10 in order, r_empty=1.
REQ-038 Full FIFO with push 0xAA -> overflow=1, contents unchanged; err_clr -> overflow=0.
REQ-039 Empty FIFO with push 0x55 and pop in the same cycle -> underflow=1, d_count=1; next pop returns 0x55.
REQ-040 FWFT=1: push 0x3C into an empty FIFO -> next cycle r_data=0x3C, r_valid=1; pop -> r_empty=1.
REQ-041 At count 8, flush, push and pop in one cycle -> d_count=0, r_empty=1; then 20 push/pop pairs across wrap -> data order preserved.
REQ-042 Assert rst mid-burst at count 5 -> all outputs at reset values without a clock edge; after release, push 0x77 and pop -> r_data=0x77.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Read-mode constants and pointer sizing shared by the FIFO files.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FWFT_STD = 0;
    localparam int FWFT_ON  = 1;

    // One extra MSB lets equal low bits be told apart as empty vs. full.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Purpose  : Single-clock storage, one write port, one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A read of the location being written returns the new word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Purpose  : Synchronous FIFO with standard or first-word-fall-through read.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FWFT       = FWFT_STD,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_push,
    output logic                  w_full,
    output logic                  w_almost_full,
    input  logic                  r_pop,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   d_count,
    input  logic                  flush,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int            PW     = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE    = PW'(1);

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  empty, full, push_ok, pop_ok;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                   (wptr_q[PW-2:0] == rptr_q[PW-2:0]);

    always_comb begin
        push_ok     = w_push & ~full & ~flush;
        pop_ok      = r_pop & ~empty & ~flush;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + ONE;
            if (pop_ok)  rptr_d = rptr_q + ONE;
        end
        // A fresh error in the same cycle as err_clr keeps the flag set.
        overflow_d  = (overflow_q & ~err_clr)  | (w_push & full & ~flush);
        underflow_d = (underflow_q & ~err_clr) | (r_pop & empty & ~flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            // Read ahead at the next head so it is visible the cycle after.
            assign mem_re    = 1'b1;
            assign mem_raddr = rptr_d[ADDR_WIDTH-1:0];
            assign r_valid   = ~empty;
        end else begin : g_std
            logic valid_q, valid_d;

            assign mem_re    = pop_ok;
            assign mem_raddr = rptr_q[ADDR_WIDTH-1:0];
            assign valid_d   = pop_ok;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
            end

            assign r_valid = valid_q;
        end
    endgenerate

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wptr_q[ADDR_WIDTH-1:0]),
        .wdata (w_data),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (r_data)
    );

    assign d_count        = wptr_q - rptr_q;
    assign w_full         = full;
    assign r_empty        = empty;
    assign w_almost_full  = (d_count >= AF_LVL);
    assign r_almost_empty = (d_count <= AE_LVL);
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_fwft
// Purpose  : Directed checks of a standard-read and an FWFT FIFO instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_fwft;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] w_data = 8'h00;
    logic       w_push = 1'b0, r_pop = 1'b0, flush = 1'b0, err_clr = 1'b0;

    logic       w_full, w_almost_full, r_valid, r_empty, r_almost_empty, overflow, underflow;
    logic [7:0] r_data;
    logic [4:0] d_count;
    logic       f_full, f_almost_full, f_valid, f_empty, f_almost_empty, f_overflow, f_underflow;
    logic [7:0] f_data;
    logic [4:0] f_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       push, pop, fl, clr;
        logic [7:0] din;
        int         cnt;
        logic       ov, uf, rv;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .w_data(w_data), .w_push(w_push), .w_full(w_full),
        .w_almost_full(w_almost_full), .r_pop(r_pop), .r_data(r_data), .r_valid(r_valid),
        .r_empty(r_empty), .r_almost_empty(r_almost_empty), .d_count(d_count),
        .flush(flush), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .w_data(w_data), .w_push(w_push), .w_full(f_full),
        .w_almost_full(f_almost_full), .r_pop(r_pop), .r_data(f_data), .r_valid(f_valid),
        .r_empty(f_empty), .r_almost_empty(f_almost_empty), .d_count(f_count),
        .flush(flush), .overflow(f_overflow), .underflow(f_underflow), .err_clr(err_clr)
    );

    function automatic vec_t mk(input logic pu, po, fl, ec, input logic [7:0] d,
                                input int cnt, input logic ov, uf, rv, input logic [7:0] rd);
        vec_t v;
        v.push = pu; v.pop = po; v.fl = fl; v.clr = ec; v.din = d;
        v.cnt = cnt; v.ov = ov; v.uf = uf; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Flags follow from the expected count: AF_LEVEL=14, AE_LEVEL=2, depth 16.
    task automatic chk_all(input string tag, input int cnt, input logic ov, uf, rv,
                           input logic [7:0] rd);
        chk({tag, ".count"},  int'(d_count),        cnt);
        chk({tag, ".full"},   int'(w_full),         int'(cnt == 16));
        chk({tag, ".empty"},  int'(r_empty),        int'(cnt == 0));
        chk({tag, ".afull"},  int'(w_almost_full),  int'(cnt >= 14));
        chk({tag, ".aempty"}, int'(r_almost_empty), int'(cnt <= 2));
        chk({tag, ".ovf"},    int'(overflow),       int'(ov));
        chk({tag, ".udf"},    int'(underflow),      int'(uf));
        chk({tag, ".valid"},  int'(r_valid),        int'(rv));
        chk({tag, ".data"},   int'(r_data),         int'(rd));
    endtask

    task automatic step(input logic pu, po, fl, ec, input logic [7:0] d);
        w_push = pu; r_pop = po; flush = fl; err_clr = ec; w_data = d;
        @(posedge clk);
        #1;
        w_push = 1'b0; r_pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        // Starting from a full FIFO holding 0x01..0x10.
        tbl[0]  = mk(H, L, L, L, 8'hAA, 16, H, L, L, 8'h00);
        tbl[1]  = mk(H, L, L, H, 8'hAA, 16, H, L, L, 8'h00);
        tbl[2]  = mk(L, L, L, H, 8'h00, 16, L, L, L, 8'h00);
        tbl[3]  = mk(H, H, L, L, 8'hBB, 15, H, L, H, 8'h01);
        tbl[4]  = mk(L, L, L, H, 8'h00, 15, L, L, L, 8'h01);
        // Starting from an empty FIFO after draining 0x02..0x10.
        tbl[5]  = mk(H, H, L, L, 8'h55,  1, L, H, L, 8'h10);
        tbl[6]  = mk(L, H, L, L, 8'h00,  0, L, H, H, 8'h55);
        tbl[7]  = mk(L, H, L, L, 8'h00,  0, L, H, L, 8'h55);
        tbl[8]  = mk(L, L, L, H, 8'h00,  0, L, L, L, 8'h55);
        tbl[9]  = mk(L, H, L, H, 8'h00,  0, L, H, L, 8'h55);
        tbl[10] = mk(L, L, L, H, 8'h00,  0, L, L, L, 8'h55);

        #3;
        chk_all("reset", 0, L, L, L, 8'h00);
        chk("reset.f_valid", int'(f_valid), 0);
        #4 rst = 1'b0;
        @(negedge clk);

        for (int i = 1; i <= 16; i++) begin
            step(H, L, L, L, 8'(i));
            chk_all($sformatf("fill%0d", i), i, L, L, L, 8'h00);
        end

        for (int i = 0; i <= 4; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].fl, tbl[i].clr, tbl[i].din);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ov, tbl[i].uf, tbl[i].rv, tbl[i].rd);
        end

        for (int i = 2; i <= 16; i++) begin
            step(L, H, L, L, 8'h00);
            chk_all($sformatf("drain%0d", i), 16 - i, L, L, H, 8'(i));
        end

        for (int i = 5; i <= 10; i++) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].fl, tbl[i].clr, tbl[i].din);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].ov, tbl[i].uf, tbl[i].rv, tbl[i].rd);
        end

        // Flush at count 8 overrides a same-cycle push and pop.
        for (int i = 0; i < 8; i++) step(H, L, L, L, 8'(8'h20 + i));
        chk("preflush.count", int'(d_count), 8);
        step(H, H, H, L, 8'h99);
        chk_all("flush", 0, L, L, L, 8'h55);

        // Push/pop pairs carry the pointers across the wrap.
        step(H, L, L, L, 8'h40);
        for (int i = 1; i < 20; i++) begin
            step(H, H, L, L, 8'(8'h40 + i));
            chk_all($sformatf("wrap%0d", i), 1, L, L, H, 8'(8'h40 + i - 1));
        end
        step(L, H, L, L, 8'h00);
        chk_all("wrap_last", 0, L, L, H, 8'h53);

        step(H, L, L, L, 8'h3C);
        chk("fwft.push.data",  int'(f_data),  8'h3C);
        chk("fwft.push.valid", int'(f_valid), 1);
        chk("fwft.push.empty", int'(f_empty), 0);
        chk("std.push.valid",  int'(r_valid), 0);
        step(L, H, L, L, 8'h00);
        chk("fwft.pop.empty",  int'(f_empty), 1);
        chk("fwft.pop.valid",  int'(f_valid), 0);
        chk("std.pop.data",    int'(r_data),  8'h3C);
        step(H, L, L, L, 8'h11);
        step(H, L, L, L, 8'h22);
        chk("fwft.head1", int'(f_data), 8'h11);
        step(L, H, L, L, 8'h00);
        chk("fwft.head2", int'(f_data), 8'h22);
        chk("fwft.head2.count", int'(f_count), 1);
        step(H, H, L, L, 8'h33);
        chk("fwft.bypass.data",  int'(f_data),  8'h33);
        chk("fwft.bypass.valid", int'(f_valid), 1);
        step(L, H, L, L, 8'h00);
        chk("fwft.drain.empty", int'(f_empty), 1);

        // Leave underflow set and the FIFO mid-burst, then reset between edges.
        step(L, H, L, L, 8'h00);
        chk("pre_rst.udf", int'(underflow), 1);
        for (int i = 0; i < 5; i++) step(H, L, L, L, 8'(8'h60 + i));
        step(H, H, L, L, 8'h65);
        chk_all("pre_rst", 5, L, H, H, 8'h60);
        #3 rst = 1'b1;
        #1;
        chk_all("async_rst", 0, L, L, L, 8'h00);
        chk("async_rst.f_empty", int'(f_empty), 1);
        chk("async_rst.f_data",  int'(f_data),  0);
        #2 rst = 1'b0;
        step(H, L, L, L, 8'h77);
        chk_all("post_rst.push", 1, L, L, L, 8'h00);
        step(L, H, L, L, 8'h00);
        chk_all("post_rst.pop", 0, L, L, H, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
